// File: rtl/piso_pkg.sv
// Shared constants and helpers for the PISO serializer: FSM state encoding and
// a constant-function clog2 for deriving the bit-counter width.
package piso_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-source / serial-link bundle of the PISO serializer. The master drives the
// parallel word and shift controls; the slave (the serializer) drives the stream.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             msb_first;
  logic             sin;
  logic             shift_en;
  logic             dout;
  logic             dout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    output msb_first,
    output sin,
    output shift_en,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    input  msb_first,
    input  sin,
    input  shift_en,
    output din_ready,
    output dout,
    output dout_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/piso_bit_cnt.sv
// Down-counter tracking bits left in the current word: reloads on load,
// decrements on enable and saturates at zero.
module piso_bit_cnt #(
  parameter int unsigned      CntW    = 3,
  parameter logic [CntW-1:0]  LoadVal = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready word loading, per-word shift
// direction, stall control and gap-free back-to-back words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  piso_serializer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;

  logic cnt_zero;
  logic last;
  logic word_end;
  logic ready;
  logic load;
  logic shift;

  assign last     = (state_q == ST_SHIFT) && cnt_zero;
  assign word_end = last && bus.shift_en;
  assign ready    = (state_q == ST_IDLE) || word_end;
  assign load     = bus.din_valid && ready;
  // The final bit of a word is never shifted; the register is reloaded or abandoned.
  assign shift    = (state_q == ST_SHIFT) && bus.shift_en && !cnt_zero;

  piso_bit_cnt #(
    .CntW    (CNT_W),
    .LoadVal (CNT_W'(WIDTH - 1))
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (shift),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_SHIFT;
    end else if (word_end) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    dir_d   = dir_q;
    if (load) begin
      shreg_d = bus.din;
      dir_d   = bus.msb_first;
    end else if (shift) begin
      if (dir_q) begin
        shreg_d = {shreg_q[WIDTH-2:0], bus.sin};
      end else begin
        shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    bus.dout = 1'b0;
    if (state_q == ST_SHIFT) begin
      bus.dout = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
    end
  end

  assign bus.dout_valid = (state_q == ST_SHIFT);
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.last       = last;
  assign bus.din_ready  = ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus a randomized
// run, all checked against a queue-of-pending-bits reference model.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: bits still to be emitted for the current word, in output order.
  logic m_q[$];

  function automatic logic m_ready();
    return (m_q.size() == 0) || ((m_q.size() == 1) && bus.shift_en);
  endfunction

  // {dout, dout_valid, last, busy, din_ready}
  function automatic logic [4:0] exp_vec();
    logic b;
    logic d;
    b = (m_q.size() != 0);
    d = b ? m_q[0] : 1'b0;
    return {d, b, (m_q.size() == 1), b, m_ready()};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {bus.dout, bus.dout_valid, bus.last, bus.busy, bus.din_ready};
  endfunction

  task automatic drive(input logic r, input logic dv, input logic [W-1:0] d,
                       input logic msb, input logic s, input logic se);
    @(negedge clk);
    rst_n         = r;
    bus.din_valid = dv;
    bus.din       = d;
    bus.msb_first = msb;
    bus.sin       = s;
    bus.shift_en  = se;
    #1;
  endtask

  task automatic tick();
    logic acc;
    acc = bus.din_valid && m_ready();
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
    end else begin
      if ((m_q.size() != 0) && bus.shift_en) void'(m_q.pop_front());
      if (acc) begin
        for (int i = 0; i < int'(W); i++) begin
          m_q.push_back(bus.msb_first ? bus.din[W-1-i] : bus.din[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", dut_vec(), 5'b00001);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'b1010_0101;
    drive(1'b1, 1'b1, W'(8'hA5), 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL lsb_model bit %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ({bus.dout, bus.last} !== {seq[7-i], 1'(i == 7)}) begin
        n_bad++;
        $display("FAIL lsb_seq bit %0d: got dout/last %b%b want %b%b", i, bus.dout,
                 bus.last, seq[7-i], 1'(i == 7));
      end
      tick();
    end
    drive(1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL lsb_idle: got %b want %b", dut_vec(), 5'b00001);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    seq = 8'b1010_0101;
    drive(1'b1, 1'b1, W'(8'hA5), 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      // Direction input flips mid-word; the captured direction must win.
      drive(1'b1, 1'b0, W'($urandom), 1'(i < 3), 1'($urandom), 1'b1);
      n_cmp++;
      if ({bus.dout, bus.last, bus.dout_valid} !== {seq[7-i], 1'(i == 7), 1'b1}) begin
        n_bad++;
        $display("FAIL msb_seq bit %0d: got dout/last/valid %b%b%b want %b%b1", i,
                 bus.dout, bus.last, bus.dout_valid, seq[7-i], 1'(i == 7));
      end
      tick();
    end
    drive(1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL msb_idle: got %b want %b", dut_vec(), 5'b00001);
    end
  endtask

  task automatic test_back_to_back();
    logic       dv;
    logic       acc;
    int unsigned n_valid;
    drive(1'b1, 1'b1, W'(8'hFF), 1'b0, 1'b0, 1'b1);
    tick();
    dv      = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, dv, W'(8'h00), 1'($urandom), 1'($urandom), 1'b1);
      if (bus.dout_valid === 1'b1) n_valid++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL b2b_model cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ({bus.dout, bus.din_ready} !== {1'(i < 8), 1'(i == 7 || i == 15)}) begin
        n_bad++;
        $display("FAIL b2b_ready cycle %0d: got dout/ready %b%b want %b%b", i, bus.dout,
                 bus.din_ready, 1'(i < 8), 1'(i == 7 || i == 15));
      end
      acc = dv && m_ready();
      tick();
      if (acc) dv = 1'b0;
    end
    n_cmp++;
    if (n_valid != 16) begin
      n_bad++;
      $display("FAIL b2b_valid_count: got %0d want 16", n_valid);
    end
    drive(1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL b2b_idle: got %b want %b", dut_vec(), 5'b00001);
    end
  endtask

  task automatic test_stall();
    logic [7:0] w;
    int         idx;
    w = 8'h3C;
    drive(1'b1, 1'b1, W'(w), 1'b1, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'(!(k >= 2 && k <= 4)));
      idx = (k <= 2) ? k : ((k <= 5) ? 2 : k - 3);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stall_model cycle %0d: got %b want %b", k, dut_vec(), exp_vec());
      end
      n_cmp++;
      if ({bus.dout, bus.last, bus.dout_valid} !== {w[7-idx], 1'(k == 10), 1'b1}) begin
        n_bad++;
        $display("FAIL stall_seq cycle %0d: got dout/last/valid %b%b%b want %b%b1", k,
                 bus.dout, bus.last, bus.dout_valid, w[7-idx], 1'(k == 10));
      end
      tick();
    end
    drive(1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL stall_idle: got %b want %b", dut_vec(), 5'b00001);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    logic         msb;
    w   = W'($urandom);
    msb = 1'($urandom);
    drive(1'b1, 1'b1, w, msb, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    tick();
    drive(1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec() !== 5'b00001) begin
      n_bad++;
      $display("FAIL midreset_idle: got %b want %b", dut_vec(), 5'b00001);
    end
    w   = W'($urandom);
    msb = 1'($urandom);
    drive(1'b1, 1'b1, w, msb, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < int'(W); i++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      n_cmp++;
      if (bus.dout !== (msb ? w[W-1-i] : w[i])) begin
        n_bad++;
        $display("FAIL midreset_reload bit %0d: got %b want %b", i, bus.dout,
                 (msb ? w[W-1-i] : w[i]));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic         dv;
    logic [W-1:0] d;
    logic         acc;
    logic         r;
    dv = 1'b0;
    d  = '0;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(99) != 0);
      drive(r, dv, d, 1'($urandom), 1'($urandom), ($urandom_range(9) < 7));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      acc = dv && m_ready() && r;
      tick();
      // Source keeps a pending word steady until it is accepted.
      if (!dv || acc || !r) begin
        dv = ($urandom_range(3) != 0);
        d  = W'($urandom);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.msb_first = 1'b0;
    bus.sin       = 1'b0;
    bus.shift_en  = 1'b0;

    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
